onehot_regfile: RTL and testbench

16-entry register file for the datapath, sitting directly downstream of the 4-to-16 write-address decoder. It takes the decoder's 16-bit one-hot write select, commits write data to the selected register on the clock edge, and serves two combinational read ports. Register 0 is hardwired to zero. Malformed write selects (not exactly one-hot) are rejected and flagged.

---
 rtl/onehot_regfile_if.sv | 25 ++
 rtl/onehot_regfile.sv | 46 ++++
 tb/tb_onehot_regfile.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/onehot_regfile_if.sv
// Write/read bundle between the datapath and the one-hot register file.
// Master drives the write/read requests; slave returns read data and status.
interface onehot_regfile_if #(
  parameter int WIDTH = 16
);
  logic             we;
  logic [15:0]      wsel;
  logic [WIDTH-1:0] wdata;
  logic [3:0]       ra1;
  logic [3:0]       ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             sel_err;
  logic [7:0]       wr_count;

  modport master (
    output we, wsel, wdata, ra1, ra2,
    input  rd1, rd2, sel_err, wr_count
  );

  modport slave (
    input  we, wsel, wdata, ra1, ra2,
    output rd1, rd2, sel_err, wr_count
  );
endinterface

// File: rtl/onehot_regfile.sv
// 16-entry register file with one-hot write select; 1-cycle write, 0-cycle reads.
// No backpressure: a write is accepted every cycle, malformed selects are dropped and flagged.
module onehot_regfile #(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  onehot_regfile_if.slave   rf
);

  logic [WIDTH-1:0] regs [16];
  logic             sel_err;
  logic [7:0]       wr_count;
  logic             onehot;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign onehot = (rf.wsel != 16'h0000) && ((rf.wsel & (rf.wsel - 16'd1)) == 16'h0000);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
      sel_err  <= 1'b0;
      wr_count <= 8'd0;
    end else if (rf.we) begin
      if (onehot) begin
        // Entry 0 is never written, so it holds its reset value of zero.
        for (int i = 1; i < 16; i++) begin
          if (rf.wsel[i]) begin
            regs[i] <= rf.wdata;
          end
        end
        wr_count <= wr_count + 8'd1;
      end else begin
        sel_err <= 1'b1;
      end
    end
  end

  assign rf.rd1      = regs[rf.ra1];
  assign rf.rd2      = regs[rf.ra2];
  assign rf.sel_err  = sel_err;
  assign rf.wr_count = wr_count;

endmodule

// File: tb/tb_onehot_regfile.sv
// Self-checking bench for onehot_regfile: directed vector table plus hand sequences
// for reset, same-cycle read/write, illegal selects and counter wrap.
module tb_onehot_regfile;

  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  onehot_regfile_if #(.WIDTH(WIDTH)) ifc ();

  onehot_regfile #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] wsel;
    logic [15:0] wdata;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [15:0] exp_rd1;
    logic [15:0] exp_rd2;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ifc.we = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    ifc.we     = 1'b0;
    ifc.wsel   = 16'h0000;
    ifc.wdata  = 16'h0000;
    ifc.ra1    = 4'd0;
    ifc.ra2    = 4'd0;

    vecs[0] = '{1'b0, 16'hFFFF, 16'h1234, 4'd1,  4'd15, 16'h0000, 16'h0000, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 16'h0002, 16'h1234, 4'd1,  4'd1,  16'h1234, 16'h1234, 1'b0, 8'd1};
    vecs[2] = '{1'b1, 16'h8000, 16'h8001, 4'd15, 4'd1,  16'h8001, 16'h1234, 1'b0, 8'd2};
    vecs[3] = '{1'b1, 16'h0001, 16'hFFFF, 4'd0,  4'd15, 16'h0000, 16'h8001, 1'b0, 8'd3};
    vecs[4] = '{1'b1, 16'h0004, 16'h00FF, 4'd2,  4'd1,  16'h00FF, 16'h1234, 1'b0, 8'd4};
    vecs[5] = '{1'b1, 16'h0004, 16'hFF00, 4'd2,  4'd2,  16'hFF00, 16'hFF00, 1'b0, 8'd5};
    vecs[6] = '{1'b1, 16'h0006, 16'hDEAD, 4'd1,  4'd2,  16'h1234, 16'hFF00, 1'b1, 8'd5};
    vecs[7] = '{1'b0, 16'h0000, 16'h0000, 4'd15, 4'd0,  16'h8001, 16'h0000, 1'b1, 8'd5};
    vecs[8] = '{1'b1, 16'h0008, 16'hBEEF, 4'd3,  4'd2,  16'hBEEF, 16'hFF00, 1'b1, 8'd6};
    vecs[9] = '{1'b1, 16'hC000, 16'h0001, 4'd14, 4'd15, 16'h0000, 16'h8001, 1'b1, 8'd6};

    // Reset state on every address of both ports.
    do_reset();
    for (int a = 0; a < 16; a++) begin
      ifc.ra1 = 4'(a);
      ifc.ra2 = 4'(15 - a);
      #1;
      chk($sformatf("reset_rd1[%0d]", a), 32'(ifc.rd1), 32'h0);
      chk($sformatf("reset_rd2[%0d]", 15 - a), 32'(ifc.rd2), 32'h0);
    end
    chk("reset_sel_err", 32'(ifc.sel_err), 32'h0);
    chk("reset_wr_count", 32'(ifc.wr_count), 32'h0);

    // Write every register back to back, then read all back.
    for (int i = 0; i < 16; i++) begin
      ifc.we    = 1'b1;
      ifc.wsel  = 16'(1 << i);
      ifc.wdata = 16'hA000 + 16'(i);
      tick();
    end
    ifc.we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ifc.ra1 = 4'(i);
      ifc.ra2 = 4'(i);
      #1;
      chk($sformatf("wr_all_rd1[%0d]", i), 32'(ifc.rd1), (i == 0) ? 32'h0 : 32'hA000 + 32'(i));
      chk($sformatf("wr_all_rd2[%0d]", i), 32'(ifc.rd2), (i == 0) ? 32'h0 : 32'hA000 + 32'(i));
    end
    chk("wr_all_count", 32'(ifc.wr_count), 32'd16);
    chk("wr_all_sel_err", 32'(ifc.sel_err), 32'h0);

    // Same-cycle read of a register being written returns the old value.
    ifc.we    = 1'b1;
    ifc.wsel  = 16'h0020;
    ifc.wdata = 16'h1111;
    tick();
    ifc.wdata = 16'h2222;
    ifc.ra1   = 4'd5;
    #1;
    chk("rw_before_edge", 32'(ifc.rd1), 32'h1111);
    tick();
    ifc.we = 1'b0;
    chk("rw_after_edge", 32'(ifc.rd1), 32'h2222);
    chk("rw_count", 32'(ifc.wr_count), 32'd18);

    // Two-bit select is rejected.
    ifc.we    = 1'b1;
    ifc.wsel  = 16'h0006;
    ifc.wdata = 16'h5555;
    ifc.ra1   = 4'd1;
    ifc.ra2   = 4'd2;
    tick();
    ifc.we = 1'b0;
    chk("bad2_r1", 32'(ifc.rd1), 32'hA001);
    chk("bad2_r2", 32'(ifc.rd2), 32'hA002);
    chk("bad2_sel_err", 32'(ifc.sel_err), 32'h1);
    chk("bad2_count", 32'(ifc.wr_count), 32'd18);

    // Vector table from a fresh reset.
    do_reset();
    for (int v = 0; v < 10; v++) begin
      ifc.we    = vecs[v].we;
      ifc.wsel  = vecs[v].wsel;
      ifc.wdata = vecs[v].wdata;
      ifc.ra1   = vecs[v].ra1;
      ifc.ra2   = vecs[v].ra2;
      tick();
      chk($sformatf("vec%0d_rd1", v), 32'(ifc.rd1), 32'(vecs[v].exp_rd1));
      chk($sformatf("vec%0d_rd2", v), 32'(ifc.rd2), 32'(vecs[v].exp_rd2));
      chk($sformatf("vec%0d_sel_err", v), 32'(ifc.sel_err), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_count", v), 32'(ifc.wr_count), 32'(vecs[v].exp_cnt));
    end
    ifc.we = 1'b0;

    // Empty select with enable flags an error.
    do_reset();
    chk("zero_pre_sel_err", 32'(ifc.sel_err), 32'h0);
    ifc.we   = 1'b1;
    ifc.wsel = 16'h0000;
    tick();
    ifc.we = 1'b0;
    chk("zero_sel_err", 32'(ifc.sel_err), 32'h1);
    chk("zero_count", 32'(ifc.wr_count), 32'd0);

    // Malformed select without enable is ignored.
    do_reset();
    ifc.we   = 1'b0;
    ifc.wsel = 16'hFFFF;
    tick();
    tick();
    chk("noen_sel_err", 32'(ifc.sel_err), 32'h0);

    // Reset between edges waits for the edge, and beats a simultaneous write.
    ifc.we    = 1'b1;
    ifc.wsel  = 16'h0010;
    ifc.wdata = 16'h4444;
    ifc.ra1   = 4'd4;
    ifc.ra2   = 4'd3;
    tick();
    ifc.wsel  = 16'h0008;
    ifc.wdata = 16'hBEEF;
    rst_n     = 1'b0;
    #1;
    chk("midrst_r4_held", 32'(ifc.rd1), 32'h4444);
    chk("midrst_count_held", 32'(ifc.wr_count), 32'd1);
    tick();
    rst_n  = 1'b1;
    ifc.we = 1'b0;
    chk("rstpri_r3", 32'(ifc.rd2), 32'h0);
    chk("rstpri_r4", 32'(ifc.rd1), 32'h0);
    chk("rstpri_count", 32'(ifc.wr_count), 32'd0);

    // 257 legal writes wrap the counter to 1.
    ifc.we   = 1'b1;
    ifc.wsel = 16'h0080;
    ifc.ra1  = 4'd7;
    for (int i = 1; i <= 257; i++) begin
      ifc.wdata = 16'(i);
      tick();
      if (i == 255) chk("wrap_255", 32'(ifc.wr_count), 32'd255);
      if (i == 256) chk("wrap_256", 32'(ifc.wr_count), 32'd0);
    end
    ifc.we = 1'b0;
    chk("wrap_257", 32'(ifc.wr_count), 32'd1);
    chk("wrap_r7", 32'(ifc.rd1), 32'd257);
    tick();
    chk("idle_count", 32'(ifc.wr_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
